stopwatch_timer: RTL and testbench

//  Parametrised up/down stopwatch and countdown timer with lap capture. Produces six BCD digits (MM:SS.cc).
//  A prescaler divides the system clock to a centisecond tick. The block feeds the seven-segment display mux
//  and replaces the fixed 50 MHz up-only divider/counter.

---
 rtl/stopwatch_timer.sv | 217 +++++++++++++++++++++
 tb/tb_stopwatch_timer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_timer.sv
// Up/down stopwatch and countdown timer with lap capture.
// Six BCD digits MM:SS.cc, advanced by a prescaled centisecond tick.
module stopwatch_timer #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100,
    parameter bit WRAP_UP = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        load,
    input  logic [23:0] load_digits,
    input  logic        mode,
    input  logic        lap,
    output logic [23:0] digits,
    output logic [23:0] lap_digits,
    output logic        lap_valid,
    output logic        running,
    output logic        expired,
    output logic        tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

    localparam logic [23:0] D_ZERO = 24'h000000;
    localparam logic [23:0] D_ONE  = 24'h000001;
    localparam logic [23:0] D_MAX  = 24'h595999;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_EXP
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nx;
    logic [23:0]   r_digits;
    logic [23:0]   w_digits_nx;
    logic [23:0]   r_lap;
    logic [23:0]   w_lap_nx;
    logic          r_mode;
    logic          w_mode_nx;
    logic          r_lap_valid;
    logic          w_lap_valid_nx;

    logic          w_tick;
    logic          w_zero;
    logic          w_one;
    logic          w_max;
    logic          w_lap_ok;
    logic [23:0]   w_inc;
    logic [23:0]   w_dec;
    logic [23:0]   w_clamp;

    // Digit order from LSB: c1, c10, s1, s10, m1, m10.
    function automatic logic [3:0] f_max(input int idx);
        return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [23:0] f_inc(input logic [23:0] d);
        logic [23:0] r;
        logic        carry;
        r     = d;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (d[i*4 +: 4] >= f_max(i)) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = d[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [23:0] f_dec(input logic [23:0] d);
        logic [23:0] r;
        logic        borrow;
        r      = d;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (d[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = f_max(i);
                end else begin
                    r[i*4 +: 4] = d[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [23:0] f_clamp(input logic [23:0] d);
        logic [23:0] r;
        r = d;
        for (int i = 0; i < 6; i++) begin
            if (d[i*4 +: 4] > f_max(i)) begin
                r[i*4 +: 4] = f_max(i);
            end
        end
        return r;
    endfunction

    always_comb begin
        w_tick   = (r_state == S_RUN) && (r_presc == P_LAST);
        w_zero   = (r_digits == D_ZERO);
        w_one    = (r_digits == D_ONE);
        w_max    = (r_digits == D_MAX);
        w_lap_ok = lap && ((r_state == S_RUN) || (r_state == S_PAUSE));
        w_inc    = f_inc(r_digits);
        w_dec    = f_dec(r_digits);
        w_clamp  = f_clamp(load_digits);
    end

    always_comb begin
        w_state_nx     = r_state;
        w_presc_nx     = r_presc;
        w_digits_nx    = r_digits;
        w_mode_nx      = r_mode;
        w_lap_nx       = r_lap;
        w_lap_valid_nx = 1'b0;

        // Snapshot is taken independently so a coincident clear still records it.
        if (w_lap_ok) begin
            w_lap_nx       = r_digits;
            w_lap_valid_nx = 1'b1;
        end

        if (clear) begin
            w_state_nx  = S_IDLE;
            w_presc_nx  = '0;
            w_digits_nx = D_ZERO;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (load) begin
                        w_digits_nx = w_clamp;
                        w_presc_nx  = '0;
                    end else if (start_stop && !(mode && w_zero)) begin
                        w_state_nx = S_RUN;
                        w_mode_nx  = mode;
                    end
                end
                S_RUN: begin
                    w_presc_nx = w_tick ? '0 : r_presc + PW'(1);
                    if (start_stop) begin
                        w_state_nx = S_PAUSE;
                    end
                    // A count step that expires wins over a same-cycle pause.
                    if (w_tick) begin
                        if (r_mode) begin
                            if (w_one || w_zero) begin
                                w_digits_nx = D_ZERO;
                                w_state_nx  = S_EXP;
                            end else begin
                                w_digits_nx = w_dec;
                            end
                        end else if (w_max && !WRAP_UP) begin
                            w_state_nx = S_EXP;
                        end else begin
                            w_digits_nx = w_inc;
                        end
                    end
                end
                S_PAUSE: begin
                    if (load) begin
                        w_digits_nx = w_clamp;
                        w_presc_nx  = '0;
                    end else if (start_stop) begin
                        w_state_nx = S_RUN;
                    end
                end
                S_EXP: begin
                    w_state_nx = S_EXP;
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_presc     <= '0;
            r_digits    <= D_ZERO;
            r_lap       <= D_ZERO;
            r_mode      <= 1'b0;
            r_lap_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_presc     <= w_presc_nx;
            r_digits    <= w_digits_nx;
            r_lap       <= w_lap_nx;
            r_mode      <= w_mode_nx;
            r_lap_valid <= w_lap_valid_nx;
        end
    end

    assign digits     = r_digits;
    assign lap_digits = r_lap;
    assign lap_valid  = r_lap_valid;
    assign running    = (r_state == S_RUN);
    assign expired    = (r_state == S_EXP);
    assign tick       = w_tick;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Scoreboard bench for stopwatch_timer at DIV=10.
// Runs a wrapping and a non-wrapping instance on shared stimulus.
module tb_stopwatch_timer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [23:0] load_digits = 24'h0;
    logic        mode = 1'b0;
    logic        lap = 1'b0;

    logic [23:0] digits, lap_digits;
    logic        lap_valid, running, expired, tick;
    logic [23:0] nw_digits, nw_lap_digits;
    logic        nw_lap_valid, nw_running, nw_expired, nw_tick;

    int n_cmp = 0;
    int n_err = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    stopwatch_timer #(.CLK_HZ(10), .TICK_HZ(1), .WRAP_UP(1'b1)) dut (
        .clock(clock), .reset(reset), .start_stop(start_stop),
        .clear(clear), .load(load), .load_digits(load_digits),
        .mode(mode), .lap(lap), .digits(digits),
        .lap_digits(lap_digits), .lap_valid(lap_valid),
        .running(running), .expired(expired), .tick(tick)
    );

    stopwatch_timer #(.CLK_HZ(10), .TICK_HZ(1), .WRAP_UP(1'b0)) dut_nw (
        .clock(clock), .reset(reset), .start_stop(start_stop),
        .clear(clear), .load(load), .load_digits(load_digits),
        .mode(mode), .lap(lap), .digits(nw_digits),
        .lap_digits(nw_lap_digits), .lap_valid(nw_lap_valid),
        .running(nw_running), .expired(nw_expired), .tick(nw_tick)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk("sb_depth", 32'(exp_q.size()), 32'd1);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        chk(t, obs, e);
    endtask

    function automatic logic [23:0] to_bcd(input int cs);
        int cc, s, m;
        cc = cs % 100;
        s  = (cs / 100) % 60;
        m  = (cs / 6000) % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10),
                4'(s % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        @(negedge clock);
        start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic do_load(input logic [23:0] v);
        load_digits = v;
        load        = 1'b1;
        @(negedge clock);
        load        = 1'b0;
    endtask

    // Bounded: a missing tick shows up as a wrong cycle count.
    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
        end while (!tick && cnt < 40);
    endtask

    initial begin
        int c;
        int tk;

        cyc(2);
        sb_push("rst_digits", 32'h0);
        sb_push("rst_lap", 32'h0);
        sb_push("rst_flags", 32'h0);
        sb_pop(32'(digits));
        sb_pop(32'(lap_digits));
        sb_pop(32'({lap_valid, running, expired, tick}));
        reset = 1'b0;
        cyc(1);

        // Up run: 100 ticks of 10 cycles each.
        mode = 1'b0;
        sb_push("start_lat", 32'd10);
        pulse_ss();
        wait_tick(c);
        sb_pop(32'(c + 1));
        sb_push("dig_t1", 32'(to_bcd(0)));
        sb_push("running", 32'd1);
        sb_pop(32'(digits));
        sb_pop(32'(running));
        for (int i = 2; i <= 100; i++) begin
            sb_push("period", 32'd10);
            sb_push("dig_tick", 32'(to_bcd(i - 1)));
            wait_tick(c);
            sb_pop(32'(c));
            sb_pop(32'(digits));
        end
        cyc(1);
        sb_push("up_1s", 32'h000100);
        sb_pop(32'(digits));

        // Pause with prescaler frozen at 4, resume six cycles to tick.
        cyc(3);
        pulse_ss();
        sb_push("pause_run", 32'd0);
        sb_pop(32'(running));
        tk = 0;
        repeat (50) begin
            @(negedge clock);
            if (tick) tk++;
        end
        sb_push("pause_ticks", 32'd0);
        sb_push("pause_dig", 32'(to_bcd(100)));
        sb_pop(32'(tk));
        sb_pop(32'(digits));
        sb_push("resume_lat", 32'd6);
        pulse_ss();
        wait_tick(c);
        sb_pop(32'(c + 1));
        cyc(1);
        sb_push("resume_dig", 32'(to_bcd(101)));
        sb_pop(32'(digits));

        // Lap on a tick cycle at 00:00.41.
        pulse_clear();
        do_load(24'h000041);
        pulse_ss();
        wait_tick(c);
        sb_push("lap_pre", 32'h000041);
        sb_pop(32'(digits));
        lap = 1'b1;
        sb_push("lap_valid", 32'd1);
        sb_push("lap_dig", 32'h000041);
        sb_push("lap_post", 32'h000042);
        @(negedge clock);
        lap = 1'b0;
        sb_pop(32'(lap_valid));
        sb_pop(32'(lap_digits));
        sb_pop(32'(digits));
        @(negedge clock);
        sb_push("lap_pulse", 32'd0);
        sb_pop(32'(lap_valid));

        // Lap together with clear: snapshot taken and clear applied.
        lap   = 1'b1;
        clear = 1'b1;
        sb_push("lc_lap", 32'h000042);
        sb_push("lc_valid", 32'd1);
        sb_push("lc_run", 32'd0);
        sb_push("lc_dig", 32'h0);
        @(negedge clock);
        lap   = 1'b0;
        clear = 1'b0;
        sb_pop(32'(lap_digits));
        sb_pop(32'(lap_valid));
        sb_pop(32'(running));
        sb_pop(32'(digits));

        // Wrap at 59:59.99 for both WRAP_UP settings.
        do_load(24'h595999);
        pulse_ss();
        wait_tick(c);
        sb_push("wrap_pre", 32'h595999);
        sb_pop(32'(digits));
        cyc(1);
        sb_push("wrap_dig", 32'h0);
        sb_push("wrap_run", 32'd1);
        sb_push("hold_dig", 32'h595999);
        sb_push("hold_exp", 32'd1);
        sb_push("hold_run", 32'd0);
        sb_pop(32'(digits));
        sb_pop(32'(running));
        sb_pop(32'(nw_digits));
        sb_pop(32'(nw_expired));
        sb_pop(32'(nw_running));
        pulse_clear();

        // Countdown from 00:00.03 to expiry.
        do_load(24'h000003);
        mode = 1'b1;
        pulse_ss();
        mode = 1'b0;
        for (int i = 3; i >= 1; i--) begin
            sb_push("cd_dig", 32'(to_bcd(i)));
            wait_tick(c);
            sb_pop(32'(digits));
        end
        cyc(1);
        sb_push("cd_zero", 32'h0);
        sb_push("cd_exp", 32'd1);
        sb_push("cd_run", 32'd0);
        sb_pop(32'(digits));
        sb_pop(32'(expired));
        sb_pop(32'(running));
        pulse_ss();
        sb_push("exp_ss", 32'd1);
        sb_pop(32'(expired));
        do_load(24'h000500);
        sb_push("exp_load", 32'h0);
        sb_pop(32'(digits));
        lap = 1'b1;
        @(negedge clock);
        lap = 1'b0;
        sb_push("exp_lap", 32'd0);
        sb_pop(32'(lap_valid));
        pulse_clear();
        sb_push("clr_exp", 32'd0);
        sb_push("clr_run", 32'd0);
        sb_pop(32'(expired));
        sb_pop(32'(running));

        // Load clamping and load ignored during RUN.
        do_load(24'hFFFFFF);
        sb_push("clamp_all", 32'h595999);
        sb_pop(32'(digits));
        do_load(24'h0F0A0B);
        sb_push("clamp_mix", 32'h090909);
        sb_pop(32'(digits));
        do_load(24'h123456);
        pulse_ss();
        cyc(2);
        do_load(24'h000000);
        sb_push("run_load", 32'h123456);
        sb_pop(32'(digits));
        pulse_clear();

        // Countdown start at zero is refused.
        mode = 1'b1;
        pulse_ss();
        sb_push("cd0_run", 32'd0);
        sb_pop(32'(running));
        tk = 0;
        repeat (15) begin
            @(negedge clock);
            if (tick) tk++;
        end
        sb_push("cd0_ticks", 32'd0);
        sb_pop(32'(tk));
        mode = 1'b0;

        // Load beats start_stop; clear beats start_stop.
        load_digits = 24'h000200;
        load        = 1'b1;
        start_stop  = 1'b1;
        @(negedge clock);
        load       = 1'b0;
        start_stop = 1'b0;
        sb_push("ls_run", 32'd0);
        sb_push("ls_dig", 32'h000200);
        sb_pop(32'(running));
        sb_pop(32'(digits));
        pulse_ss();
        sb_push("ls_start", 32'd1);
        sb_pop(32'(running));
        clear      = 1'b1;
        start_stop = 1'b1;
        @(negedge clock);
        clear      = 1'b0;
        start_stop = 1'b0;
        sb_push("cs_run", 32'd0);
        sb_push("cs_dig", 32'h0);
        sb_pop(32'(running));
        sb_pop(32'(digits));

        // Asynchronous reset mid-RUN, between clock edges.
        do_load(24'h000700);
        pulse_ss();
        cyc(3);
        lap = 1'b1;
        @(negedge clock);
        lap = 1'b0;
        sb_push("pre_rst_lv", 32'd1);
        sb_pop(32'(lap_valid));
        #2 reset = 1'b1;
        #1;
        sb_push("ar_digits", 32'h0);
        sb_push("ar_lap", 32'h0);
        sb_push("ar_flags", 32'h0);
        sb_pop(32'(digits));
        sb_pop(32'(lap_digits));
        sb_pop(32'({lap_valid, running, expired, tick}));
        @(negedge clock);
        reset = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
